// File: rtl/druaga_video_timing.sv
// rtl/druaga_video_timing.sv - Druaga/Super Pacman beam counters, clock enables, blanking, syncs, VBLANK IRQ.
// Optional per-frame sync shift (HOFS/VOFS) is built only when VTIMING_SHIFT_EN is defined.
module druaga_video_timing #(
   parameter int H_TOTAL    = 384,
   parameter int H_BLK_BEG  = 290,
   parameter int H_BLK_END  = 16,
   parameter int H_SYNC_BEG = 310,
   parameter int H_SYNC_LEN = 32,
   parameter int V_TOTAL    = 264,
   parameter int V_BLK_BEG  = 224,
   parameter int V_SYNC_BEG = 240,
   parameter int V_SYNC_LEN = 3
) (
   input  logic       VCLKx8,
   input  logic       RESET,
   output logic       CE4,
   output logic       CE1,
   output logic [8:0] PH,
   output logic [8:0] PV,
   output logic       HBLANK,
   output logic       VBLANK,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       VB_IRQ,
   output logic [7:0] FRAME,
   input  logic [3:0] HOFS,
   input  logic [3:0] VOFS
);

   logic [2:0]        div;
   logic              h_wrap;
   logic              v_wrap;
   logic              f_wrap;
   logic [8:0]        next_ph;
   logic [8:0]        next_pv;
   logic signed [3:0] eff_hofs;
   logic signed [3:0] eff_vofs;

   // Modular window test: is cnt inside [beg+ofs, beg+ofs+len) taken modulo total.
   function automatic logic in_window(input int cnt, input int beg, input int len,
                                      input int total, input int ofs);
      int d;
      d = cnt + 2 * total - beg - ofs;
      if (d >= 2 * total) d = d - 2 * total;
      if (d >= total) d = d - total;
      return d < len;
   endfunction

   assign CE4 = div[0];
   assign CE1 = (div == 3'b111);

   always_comb begin
      h_wrap  = (PH == 9'(H_TOTAL - 1));
      v_wrap  = (PV == 9'(V_TOTAL - 1));
      f_wrap  = h_wrap && v_wrap;
      next_ph = h_wrap ? 9'd0 : PH + 9'd1;
      next_pv = PV;
      if (h_wrap) next_pv = v_wrap ? 9'd0 : PV + 9'd1;
   end

`ifdef VTIMING_SHIFT_EN
   logic signed [3:0] hofs_q;
   logic signed [3:0] vofs_q;

   always_ff @(posedge VCLKx8 or posedge RESET) begin
      if (RESET) begin
         hofs_q <= '0;
         vofs_q <= '0;
      end else if (CE1 && f_wrap) begin
         hofs_q <= $signed(HOFS);
         vofs_q <= $signed(VOFS);
      end
   end

   // The frame-boundary edge already decodes line 0 of the new frame, so it uses the incoming offsets.
   assign eff_hofs = f_wrap ? $signed(HOFS) : hofs_q;
   assign eff_vofs = f_wrap ? $signed(VOFS) : vofs_q;
`else
   logic unused_ofs;
   assign unused_ofs = ^{HOFS, VOFS};
   assign eff_hofs   = '0;
   assign eff_vofs   = '0;
`endif

   // Flags decode next_ph/next_pv so they land on the same edge as the counts they describe.
   always_ff @(posedge VCLKx8 or posedge RESET) begin
      if (RESET) begin
         div    <= '0;
         PH     <= '0;
         PV     <= '0;
         FRAME  <= '0;
         HBLANK <= 1'b0;
         VBLANK <= 1'b0;
         HSYNC  <= 1'b0;
         VSYNC  <= 1'b0;
         VB_IRQ <= 1'b0;
      end else begin
         div    <= div + 3'd1;
         VB_IRQ <= 1'b0;
         if (CE1) begin
            PH <= next_ph;
            PV <= next_pv;
            if (f_wrap) FRAME <= FRAME + 8'd1;
            HBLANK <= (next_ph >= 9'(H_BLK_BEG)) || (next_ph < 9'(H_BLK_END));
            VBLANK <= (next_pv >= 9'(V_BLK_BEG));
            HSYNC  <= in_window(int'(next_ph), H_SYNC_BEG, H_SYNC_LEN, H_TOTAL, int'(eff_hofs));
            VSYNC  <= in_window(int'(next_pv), V_SYNC_BEG, V_SYNC_LEN, V_TOTAL, int'(eff_vofs));
            VB_IRQ <= h_wrap && (next_pv == 9'(V_BLK_BEG));
         end
      end
   end

endmodule

// File: tb/tb_druaga_video_timing.sv
// tb/tb_druaga_video_timing.sv - Self-checking bench: boundary table, arithmetic beam model, shift and async-reset sequences.
module tb_druaga_video_timing;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] hofs_in = 4'd0;
   logic [3:0] vofs_in = 4'd0;

   logic       ce4_o [3];
   logic       ce1_o [3];
   logic [8:0] ph_o  [3];
   logic [8:0] pv_o  [3];
   logic       hb_o  [3];
   logic       vb_o  [3];
   logic       hs_o  [3];
   logic       vs_o  [3];
   logic       irq_o [3];
   logic [7:0] fr_o  [3];

   // 0: default geometry, 1: hsync window crossing the line wrap, 2: reduced frame for multi-frame runs
   int ht  [3] = '{384, 384, 48};
   int hbb [3] = '{290, 290, 36};
   int hbe [3] = '{16, 16, 4};
   int hsb [3] = '{310, 370, 40};
   int hsl [3] = '{32, 32, 6};
   int vt  [3] = '{264, 264, 20};
   int vbb [3] = '{224, 224, 14};
   int vsb [3] = '{240, 240, 16};
   int vsl [3] = '{3, 3, 3};

   int tests = 0;
   int fails = 0;
   int cyc;
   int m_ho;
   int m_vo;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   druaga_video_timing u_dut (
      .VCLKx8(clk), .RESET(rst), .CE4(ce4_o[0]), .CE1(ce1_o[0]), .PH(ph_o[0]), .PV(pv_o[0]),
      .HBLANK(hb_o[0]), .VBLANK(vb_o[0]), .HSYNC(hs_o[0]), .VSYNC(vs_o[0]), .VB_IRQ(irq_o[0]),
      .FRAME(fr_o[0]), .HOFS(hofs_in), .VOFS(vofs_in));

   druaga_video_timing #(.H_SYNC_BEG(370)) u_wrap (
      .VCLKx8(clk), .RESET(rst), .CE4(ce4_o[1]), .CE1(ce1_o[1]), .PH(ph_o[1]), .PV(pv_o[1]),
      .HBLANK(hb_o[1]), .VBLANK(vb_o[1]), .HSYNC(hs_o[1]), .VSYNC(vs_o[1]), .VB_IRQ(irq_o[1]),
      .FRAME(fr_o[1]), .HOFS(hofs_in), .VOFS(vofs_in));

   druaga_video_timing #(
      .H_TOTAL(48), .H_BLK_BEG(36), .H_BLK_END(4), .H_SYNC_BEG(40), .H_SYNC_LEN(6),
      .V_TOTAL(20), .V_BLK_BEG(14), .V_SYNC_BEG(16), .V_SYNC_LEN(3)) u_small (
      .VCLKx8(clk), .RESET(rst), .CE4(ce4_o[2]), .CE1(ce1_o[2]), .PH(ph_o[2]), .PV(pv_o[2]),
      .HBLANK(hb_o[2]), .VBLANK(vb_o[2]), .HSYNC(hs_o[2]), .VSYNC(vs_o[2]), .VB_IRQ(irq_o[2]),
      .FRAME(fr_o[2]), .HOFS(hofs_in), .VOFS(vofs_in));

   function automatic int wrapmod(input int a, input int m);
      return ((a % m) + m) % m;
   endfunction

   // Expected outputs from the number of clock edges since reset release.
   function automatic logic [32:0] expect_vec(input int i, input int c, input int ho, input int vo);
      int n, dv, p, ln, v, fr;
      logic hb, vb, hs, vs, irq;
      n  = c / 8;
      dv = c % 8;
      p  = n % ht[i];
      ln = n / ht[i];
      v  = ln % vt[i];
      fr = (ln / vt[i]) % 256;
      hb = 1'b0; vb = 1'b0; hs = 1'b0; vs = 1'b0; irq = 1'b0;
      if (n > 0) begin
         hb  = (p >= hbb[i]) || (p < hbe[i]);
         vb  = (v >= vbb[i]);
         hs  = wrapmod(p - hsb[i] - ho, ht[i]) < hsl[i];
         vs  = wrapmod(v - vsb[i] - vo, vt[i]) < vsl[i];
         irq = (dv == 0) && (p == 0) && (v == vbb[i]);
      end
      return {dv[0], (dv == 7), p[8:0], v[8:0], hb, vb, hs, vs, irq, fr[7:0]};
   endfunction

   function automatic logic [32:0] got_vec(input int i);
      return {ce4_o[i], ce1_o[i], ph_o[i], pv_o[i], hb_o[i], vb_o[i], hs_o[i], vs_o[i], irq_o[i], fr_o[i]};
   endfunction

   task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Behavioural reference: edge count since reset plus offsets captured at reduced-frame boundaries.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc  <= 0;
         m_ho <= 0;
         m_vo <= 0;
      end else begin
         if ((cyc % 8 == 7) && (((cyc / 8) + 1) % (48 * 20) == 0)) begin
`ifdef VTIMING_SHIFT_EN
            m_ho <= int'($signed(hofs_in));
            m_vo <= int'($signed(vofs_in));
`endif
         end
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++)
            check($sformatf("model%0d@%0d", i, cyc), got_vec(i),
                  expect_vec(i, cyc, (i == 2) ? m_ho : 0, (i == 2) ? m_vo : 0));
      end
   end

   task automatic wait_cyc(input int target);
      int g;
      g = 0;
      while (cyc < target && g < 100000) begin
         @(negedge clk);
         g++;
      end
      if (cyc < target) check($sformatf("timeout_cyc%0d", target), 33'(cyc), 33'(target));
   endtask

   // Position (PH for hsync, PV for vsync) where the reduced instance's sync next rises.
   task automatic sync_rise(input bit vert, output int pos);
      logic prev, cur;
      int g;
      pos  = -1;
      prev = vert ? vs_o[2] : hs_o[2];
      g    = 0;
      while (g < 20000) begin
         @(negedge clk);
         g++;
         cur = vert ? vs_o[2] : hs_o[2];
         if (cur && !prev) begin
            pos = vert ? int'(pv_o[2]) : int'(ph_o[2]);
            break;
         end
         prev = cur;
      end
   endtask

   typedef struct {
      int   cyc;
      int   inst;
      int   ph;
      int   pv;
      logic hb;
      logic hs;
   } vec_t;

   vec_t tbl [19];

   initial begin
      int pos, exp_h, exp_v, irq_seen, g;
      logic [32:0] gv, ev;

      tbl = '{
         '{0,    0, 0,   0, 1'b0, 1'b0},
         '{7,    0, 0,   0, 1'b0, 1'b0},
         '{8,    0, 1,   0, 1'b1, 1'b0},
         '{120,  0, 15,  0, 1'b1, 1'b0},
         '{128,  0, 16,  0, 1'b0, 1'b0},
         '{2312, 0, 289, 0, 1'b0, 1'b0},
         '{2320, 0, 290, 0, 1'b1, 1'b0},
         '{2472, 0, 309, 0, 1'b1, 1'b0},
         '{2480, 0, 310, 0, 1'b1, 1'b1},
         '{2728, 0, 341, 0, 1'b1, 1'b1},
         '{2736, 0, 342, 0, 1'b1, 1'b0},
         '{2952, 1, 369, 0, 1'b1, 1'b0},
         '{2960, 1, 370, 0, 1'b1, 1'b1},
         '{3064, 0, 383, 0, 1'b1, 1'b0},
         '{3064, 1, 383, 0, 1'b1, 1'b1},
         '{3072, 0, 0,   1, 1'b1, 1'b0},
         '{3072, 1, 0,   1, 1'b1, 1'b1},
         '{3208, 1, 17,  1, 1'b0, 1'b1},
         '{3216, 1, 18,  1, 1'b0, 1'b0}};

      @(posedge clk);
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check($sformatf("reset_state%0d", i), got_vec(i), 33'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      for (int k = 0; k < 19; k++) begin
         wait_cyc(tbl[k].cyc);
         gv = 33'({ph_o[tbl[k].inst], pv_o[tbl[k].inst], hb_o[tbl[k].inst], hs_o[tbl[k].inst]});
         ev = 33'({9'(tbl[k].ph), 9'(tbl[k].pv), tbl[k].hb, tbl[k].hs});
         check($sformatf("tbl%0d_cyc%0d", k, tbl[k].cyc), gv, ev);
      end

      wait_cyc(7679);
      check("frame_end_pos", 33'({fr_o[2], pv_o[2], ph_o[2]}), 33'({8'd0, 9'd19, 9'd47}));
      wait_cyc(7680);
      check("frame_wrap1", 33'({fr_o[2], pv_o[2], ph_o[2]}), 33'({8'd1, 9'd0, 9'd0}));

      wait_cyc(7680 + 8 * (48 * 2 + 5));
      hofs_in = 4'hE;
      vofs_in = 4'h1;
      sync_rise(1'b0, pos);
      check("hsync_same_frame", 33'(pos), 33'd40);

      wait_cyc(2 * 7680);
      check("frame_wrap2", 33'({fr_o[2], pv_o[2], ph_o[2]}), 33'({8'd2, 9'd0, 9'd0}));
`ifdef VTIMING_SHIFT_EN
      exp_h = 38;
      exp_v = 17;
`else
      exp_h = 40;
      exp_v = 16;
`endif
      sync_rise(1'b0, pos);
      check("hsync_next_frame", 33'(pos), 33'(exp_h));
      sync_rise(1'b1, pos);
      check("vsync_next_frame", 33'(pos), 33'(exp_v));

      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(5000, 1500)) @(posedge clk);
         #2;
         hofs_in = 4'($urandom);
         vofs_in = 4'($urandom);
      end

      g = 0;
      while (!(pv_o[2] == 9'd13 && ph_o[2] == 9'd47 && (cyc % 8) == 5) && g < 10000) begin
         @(negedge clk);
         g++;
      end
      check("reach_pv13_ph47_div5", 33'({pv_o[2], ph_o[2]}), 33'({9'd13, 9'd47}));
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("async_reset%0d", i), got_vec(i), 33'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      irq_seen = 0;
      for (int k = 0; k < 8 * 48 * 2; k++) begin
         @(negedge clk);
         if (irq_o[2]) irq_seen++;
      end
      check("no_irq_after_reset", 33'(irq_seen), 33'd0);
      check("frame_after_reset", 33'(fr_o[2]), 33'd0);

      repeat (16) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
